// File: rtl/pwm_timer_ctrl.sv
// pwm_timer_ctrl: prescaled up-counter with double-buffered period/compare feeding one PWM comparator channel
module pwm_timer_ctrl #(
    parameter int WIDTH     = 16,
    parameter int PSC_WIDTH = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic                 stop,
    input  logic                 one_shot,
    input  logic                 cfg_valid,
    output logic                 cfg_ready,
    input  logic [WIDTH-1:0]     cfg_period,
    input  logic [WIDTH-1:0]     cfg_compare,
    input  logic [PSC_WIDTH-1:0] cfg_psc,
    output logic [WIDTH-1:0]     cnt_o,
    output logic [WIDTH-1:0]     cmp_o,
    output logic [WIDTH-1:0]     period_o,
    output logic                 pwm_en_o,
    output logic                 update_o,
    output logic                 busy
);
    typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;
    state_t state, state_nx;
    logic [PSC_WIDTH-1:0] psc_active, psc_cnt, pend_psc;
    logic [WIDTH-1:0] pend_period, pend_compare;
    logic pend_valid, one_shot_q, tick, pe, accept, load, launch;
    assign cfg_ready = !pend_valid;
    // period-end detection and config handshake; a pending config loads at once when idle, else at PE
    always_comb begin
        tick   = busy && psc_cnt == psc_active;
        pe     = tick && (period_o == '0 || cnt_o == period_o - WIDTH'(1));
        accept = cfg_valid && !pend_valid;
        load   = pend_valid && (state == IDLE || pe);
        launch = state == IDLE && start && !stop;
    end
    // state register
    always_ff @(posedge clk) begin
        state <= rst ? IDLE : state_nx;
    end
    // next state: one-shot end at PE wins over a stop arriving in the same cycle
    always_comb begin
        state_nx = state;
        unique case (state)
            IDLE:    state_nx = (start && !stop) ? RUN : IDLE;
            RUN:     state_nx = (pe && one_shot_q) ? IDLE : stop ? DRAIN : RUN;
            DRAIN:   state_nx = pe ? IDLE : DRAIN;
            default: state_nx = IDLE;
        endcase
    end
    // state-decoded outputs
    always_comb begin
        busy     = state != IDLE;
        pwm_en_o = state != IDLE;
    end
    // prescaler, counter, pending buffer and active registers
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_o        <= '0;
            cmp_o        <= '0;
            period_o     <= '0;
            psc_active   <= '0;
            psc_cnt      <= '0;
            pend_period  <= '0;
            pend_compare <= '0;
            pend_psc     <= '0;
            pend_valid   <= 1'b0;
            one_shot_q   <= 1'b0;
            update_o     <= 1'b0;
        end else begin
            if (accept) begin
                pend_period  <= cfg_period;
                pend_compare <= cfg_compare;
                pend_psc     <= cfg_psc;
                pend_valid   <= 1'b1;
            end
            if (load) begin
                period_o   <= pend_period;
                cmp_o      <= pend_compare;
                psc_active <= pend_psc;
                pend_valid <= 1'b0;
            end
            if (launch)
                one_shot_q <= one_shot;
            update_o <= load;
            psc_cnt  <= (!busy || tick) ? '0 : psc_cnt + PSC_WIDTH'(1);
            cnt_o    <= (!busy || pe) ? '0 : tick ? cnt_o + WIDTH'(1) : cnt_o;
        end
    end
endmodule

// File: tb/tb_pwm_timer_ctrl.sv
// tb_pwm_timer_ctrl: scoreboard bench for pwm_timer_ctrl
module tb_pwm_timer_ctrl;
    logic        clk = 0, rst = 1, start = 0, stop = 0, one_shot = 0, cfg_valid = 0;
    logic        cfg_ready, pwm_en_o, update_o, busy;
    logic [15:0] cfg_period = 0, cfg_compare = 0, cnt_o, cmp_o, period_o;
    logic [7:0]  cfg_psc = 0;
    int checks = 0, errors = 0;

    typedef struct packed {
        logic [15:0] cnt;
        logic [15:0] cmp;
        logic        upd;
        logic        rdy;
        logic        busy;
    } exp_t;
    exp_t q[$];
    exp_t e;

    pwm_timer_ctrl #(.WIDTH(16), .PSC_WIDTH(8)) dut (
        .clk(clk), .rst(rst), .start(start), .stop(stop), .one_shot(one_shot),
        .cfg_valid(cfg_valid), .cfg_ready(cfg_ready), .cfg_period(cfg_period),
        .cfg_compare(cfg_compare), .cfg_psc(cfg_psc), .cnt_o(cnt_o), .cmp_o(cmp_o),
        .period_o(period_o), .pwm_en_o(pwm_en_o), .update_o(update_o), .busy(busy)
    );

    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    function automatic exp_t mk(input int c, input int m, input bit u, input bit r, input bit b);
        exp_t x;
        x.cnt = 16'(c); x.cmp = 16'(m); x.upd = u; x.rdy = r; x.busy = b;
        return x;
    endfunction

    task automatic cycle();
        @(posedge clk); #1;
    endtask

    task automatic load_cfg(input int p, input int c, input int s);
        cfg_period = 16'(p); cfg_compare = 16'(c); cfg_psc = 8'(s);
        cfg_valid = 1; cycle(); cfg_valid = 0; cycle(); cycle();
    endtask

    task automatic test_reset(input bit mid);
        if (mid) begin
            load_cfg(6, 4, 1);
            start = 1; cycle(); start = 0;
            repeat (8) cycle();
            checks++;
            if (busy !== 1'b1) begin
                errors++;
                $display("FAIL reset_pre_busy: got %b want 1", busy);
            end
        end
        rst = 1; repeat (3) cycle(); rst = 0;
        checks++;
        if ({cnt_o, cmp_o, period_o, update_o, cfg_ready, busy, pwm_en_o} !== {48'd0, 4'b0100}) begin
            errors++;
            $display("FAIL reset_state(mid=%0b): got cnt=%0d cmp=%0d per=%0d upd=%b rdy=%b busy=%b en=%b want 0 0 0 0 1 0 0",
                     mid, cnt_o, cmp_o, period_o, update_o, cfg_ready, busy, pwm_en_o);
        end
    endtask

    task automatic test_basic();
        int n;
        cfg_period = 10; cfg_compare = 3; cfg_psc = 0;
        cfg_valid = 1; cycle(); cfg_valid = 0;
        checks++;
        if ({cfg_ready, update_o} !== 2'b00) begin
            errors++;
            $display("FAIL cfg_accept: got rdy=%b upd=%b want 0 0", cfg_ready, update_o);
        end
        cycle();
        checks++;
        if ({update_o, cmp_o, period_o, cfg_ready} !== {1'b1, 16'd3, 16'd10, 1'b1}) begin
            errors++;
            $display("FAIL cfg_load: got upd=%b cmp=%0d per=%0d rdy=%b want 1 3 10 1", update_o, cmp_o, period_o, cfg_ready);
        end
        cycle();
        checks++;
        if ({update_o, busy} !== 2'b00) begin
            errors++;
            $display("FAIL cfg_pulse_end: got upd=%b busy=%b want 0 0", update_o, busy);
        end
        start = 1; cycle(); start = 0;
        for (int i = 0; i < 20; i++) q.push_back(mk(i % 10, 3, 0, 1, 1));
        n = q.size();
        for (int i = 0; i < n; i++) begin
            e = q.pop_front();
            checks++;
            if ({cnt_o, cmp_o, update_o, cfg_ready, busy, pwm_en_o} !== {e, e.busy}) begin
                errors++;
                $display("FAIL basic[%0d]: got cnt=%0d cmp=%0d upd=%b rdy=%b busy=%b en=%b want cnt=%0d cmp=%0d upd=%b rdy=%b busy=%b",
                         i, cnt_o, cmp_o, update_o, cfg_ready, busy, pwm_en_o, e.cnt, e.cmp, e.upd, e.rdy, e.busy);
            end
            cycle();
        end
    endtask

    task automatic test_update();
        int n;
        repeat (4) cycle();
        cfg_period = 10; cfg_compare = 7; cfg_psc = 0;
        cfg_valid = 1; cycle();
        for (int c = 5; c < 10; c++) q.push_back(mk(c, 3, 0, 0, 1));
        q.push_back(mk(0, 7, 1, 1, 1));
        q.push_back(mk(1, 7, 0, 0, 1));
        n = q.size();
        for (int i = 0; i < n; i++) begin
            e = q.pop_front();
            checks++;
            if ({cnt_o, cmp_o, update_o, cfg_ready, busy, pwm_en_o} !== {e, e.busy}) begin
                errors++;
                $display("FAIL update[%0d]: got cnt=%0d cmp=%0d upd=%b rdy=%b busy=%b en=%b want cnt=%0d cmp=%0d upd=%b rdy=%b busy=%b",
                         i, cnt_o, cmp_o, update_o, cfg_ready, busy, pwm_en_o, e.cnt, e.cmp, e.upd, e.rdy, e.busy);
            end
            cycle();
        end
        cfg_valid = 0;
    endtask

    task automatic test_stop();
        int n;
        stop = 1; cycle(); stop = 0;
        for (int c = 3; c < 10; c++) q.push_back(mk(c, 7, 0, 0, 1));
        q.push_back(mk(0, 7, 1, 1, 0));
        q.push_back(mk(0, 7, 0, 1, 0));
        n = q.size();
        for (int i = 0; i < n; i++) begin
            e = q.pop_front();
            checks++;
            if ({cnt_o, cmp_o, update_o, cfg_ready, busy, pwm_en_o} !== {e, e.busy}) begin
                errors++;
                $display("FAIL stop_drain[%0d]: got cnt=%0d cmp=%0d upd=%b rdy=%b busy=%b en=%b want cnt=%0d cmp=%0d upd=%b rdy=%b busy=%b",
                         i, cnt_o, cmp_o, update_o, cfg_ready, busy, pwm_en_o, e.cnt, e.cmp, e.upd, e.rdy, e.busy);
            end
            start = (i == 2);
            cycle();
        end
        start = 0;
    endtask

    task automatic test_prescaler();
        int n;
        int w;
        load_cfg(4, 1, 2);
        start = 1; cycle(); start = 0;
        for (int i = 0; i < 24; i++) q.push_back(mk((i / 3) % 4, 1, 0, 1, 1));
        n = q.size();
        for (int i = 0; i < n; i++) begin
            e = q.pop_front();
            checks++;
            if ({cnt_o, cmp_o, update_o, cfg_ready, busy, pwm_en_o} !== {e, e.busy}) begin
                errors++;
                $display("FAIL prescaler[%0d]: got cnt=%0d cmp=%0d upd=%b rdy=%b busy=%b en=%b want cnt=%0d cmp=%0d upd=%b rdy=%b busy=%b",
                         i, cnt_o, cmp_o, update_o, cfg_ready, busy, pwm_en_o, e.cnt, e.cmp, e.upd, e.rdy, e.busy);
            end
            cycle();
        end
        stop = 1; cycle(); stop = 0;
        w = 0;
        while (busy && w < 50) begin
            cycle();
            w++;
        end
        checks++;
        if (busy !== 1'b0) begin
            errors++;
            $display("FAIL prescaler_drain: got busy=%b after %0d cycles want 0", busy, w);
        end
    endtask

    task automatic test_one_shot();
        int n;
        load_cfg(5, 2, 0);
        one_shot = 1; start = 1; cycle(); start = 0; one_shot = 0;
        for (int c = 0; c < 5; c++) q.push_back(mk(c, 2, 0, 1, 1));
        q.push_back(mk(0, 2, 0, 1, 0));
        q.push_back(mk(0, 2, 0, 1, 0));
        n = q.size();
        for (int i = 0; i < n; i++) begin
            e = q.pop_front();
            checks++;
            if ({cnt_o, cmp_o, update_o, cfg_ready, busy, pwm_en_o} !== {e, e.busy}) begin
                errors++;
                $display("FAIL one_shot[%0d]: got cnt=%0d cmp=%0d upd=%b rdy=%b busy=%b en=%b want cnt=%0d cmp=%0d upd=%b rdy=%b busy=%b",
                         i, cnt_o, cmp_o, update_o, cfg_ready, busy, pwm_en_o, e.cnt, e.cmp, e.upd, e.rdy, e.busy);
            end
            cycle();
        end
    endtask

    task automatic test_corner();
        int n;
        load_cfg(0, 0, 0);
        start = 1; stop = 1; cycle(); start = 0; stop = 0;
        checks++;
        if ({busy, pwm_en_o, cnt_o} !== 18'd0) begin
            errors++;
            $display("FAIL start_stop_idle: got busy=%b en=%b cnt=%0d want 0 0 0", busy, pwm_en_o, cnt_o);
        end
        start = 1; cycle(); start = 0;
        cfg_period = 0; cfg_compare = 5; cfg_psc = 0;
        q.push_back(mk(0, 0, 0, 1, 1));
        q.push_back(mk(0, 0, 0, 0, 1));
        q.push_back(mk(0, 5, 1, 1, 1));
        q.push_back(mk(0, 5, 0, 1, 1));
        q.push_back(mk(0, 5, 0, 1, 1));
        q.push_back(mk(0, 5, 0, 1, 0));
        n = q.size();
        for (int i = 0; i < n; i++) begin
            e = q.pop_front();
            checks++;
            if ({cnt_o, cmp_o, update_o, cfg_ready, busy, pwm_en_o} !== {e, e.busy}) begin
                errors++;
                $display("FAIL period0[%0d]: got cnt=%0d cmp=%0d upd=%b rdy=%b busy=%b en=%b want cnt=%0d cmp=%0d upd=%b rdy=%b busy=%b",
                         i, cnt_o, cmp_o, update_o, cfg_ready, busy, pwm_en_o, e.cnt, e.cmp, e.upd, e.rdy, e.busy);
            end
            cfg_valid = (i == 0);
            stop = (i == 3);
            cycle();
        end
        cfg_valid = 0;
        stop = 0;
    endtask

    initial begin
        test_reset(0);
        test_basic();
        test_update();
        test_stop();
        test_prescaler();
        test_one_shot();
        test_corner();
        test_reset(1);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
